// File: rtl/iob_vexriscv_dbus_bridge.sv
// iob_vexriscv_dbus_bridge
//   Bridges the VexRiscv dBus cmd/rsp stream onto the IOb native bus.
//   Commands are queued in a small FIFO; the head is issued to memory one
//   transaction at a time. Only reads produce a response. Misaligned
//   commands never reach memory: reads get a local error response, writes
//   are dropped, and both bump a saturating error counter.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   cmd_*                VexRiscv dBus command (valid/ready handshake)
//   rsp_*                one-cycle read response pulse
//   m_*                  IOb native request / completion
//   err_count            saturating count of misaligned commands
module iob_vexriscv_dbus_bridge #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [ADDR_W-1:0]   cmd_address,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [DATA_W/8-1:0] cmd_mask,
  input  logic [1:0]          cmd_size,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_error,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic [7:0]          err_count
);
  localparam int STRB_W = DATA_W/8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // size only matters for the alignment check, so only its outcome is kept
  typedef struct packed {
    logic              wr;
    logic              mis;
    logic [STRB_W-1:0] mask;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, ERR} state_t;

  state_t            state_q, state_d;
  entry_t            fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              m_valid_q, m_valid_d;
  logic [ADDR_W-1:0] m_address_q, m_address_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [STRB_W-1:0] m_wstrb_q, m_wstrb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_error_q, rsp_error_d;
  logic [7:0]        err_count_q, err_count_d;

  entry_t push_entry, head, nxt;
  logic   push, pop, load, empty, full, next_avail, next_mis;

  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign rd_nxt    = rd_ptr_q + PTR_W'(1);
  assign head      = fifo_q[rd_ptr_q];
  assign nxt       = fifo_q[rd_nxt];

  always_comb begin
    push_entry      = '0;
    push_entry.wr   = cmd_wr;
    push_entry.mask = cmd_mask;
    push_entry.data = cmd_data;
    push_entry.addr = cmd_address;
    case (cmd_size)
      2'd0:    push_entry.mis = 1'b0;
      2'd1:    push_entry.mis = cmd_address[0];
      2'd2:    push_entry.mis = |cmd_address[1:0];
      default: push_entry.mis = 1'b1;
    endcase
  end

  // Head that follows a pop: the second stored entry, or the command being
  // pushed in the same cycle when only one entry is stored.
  assign next_avail = (count_q > CNT_W'(1)) || push;
  assign next_mis   = (count_q > CNT_W'(1)) ? nxt.mis : push_entry.mis;

  always_comb begin
    state_d     = state_q;
    m_valid_d   = m_valid_q;
    m_address_d = m_address_q;
    m_wdata_d   = m_wdata_q;
    m_wstrb_d   = m_wstrb_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    err_count_d = err_count_q;
    pop         = 1'b0;
    load        = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        if (head.mis) state_d = ERR;
        else begin
          state_d = ISSUE;
          load    = 1'b1;
        end
      end
      ISSUE: begin
        if (!m_valid_q) load = 1'b1;  // re-arm after a back-to-back completion
        else if (m_ready) begin
          pop       = 1'b1;
          m_valid_d = 1'b0;
          if (!head.wr) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = m_rdata;
            rsp_error_d = 1'b0;
          end
          if (next_avail) state_d = next_mis ? ERR : ISSUE;
          else            state_d = IDLE;
        end
      end
      ERR: begin
        pop = 1'b1;
        if (!head.wr) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_error_d = 1'b1;
        end
        if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      m_valid_d   = 1'b1;
      m_address_d = head.addr;
      m_wdata_d   = head.data;
      m_wstrb_d   = head.wr ? head.mask : '0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // storage carries no reset: occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      m_valid_q   <= 1'b0;
      m_address_q <= '0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      m_valid_q   <= m_valid_d;
      m_address_q <= m_address_d;
      m_wdata_q   <= m_wdata_d;
      m_wstrb_q   <= m_wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      err_count_q <= err_count_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_address = m_address_q;
  assign m_wdata   = m_wdata_q;
  assign m_wstrb   = m_wstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_error = rsp_error_q;
  assign err_count = err_count_q;
endmodule

// File: tb/tb_iob_vexriscv_dbus_bridge.sv
// Self-checking bench for iob_vexriscv_dbus_bridge: directed scenarios plus
// a randomized command stream checked against a command-order model.
`timescale 1ns/1ps
module tb_iob_vexriscv_dbus_bridge;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_wr = 1'b0;
  logic [31:0] cmd_address = '0, cmd_data = '0;
  logic [3:0]  cmd_mask = '0;
  logic [1:0]  cmd_size = '0;
  logic        cmd_ready, rsp_valid, rsp_error, m_valid, m_ready;
  logic [31:0] rsp_data, m_address, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [7:0]  err_count;

  logic        mem_auto = 1'b0, man_ready = 1'b0, auto_ready = 1'b0;
  logic [31:0] man_rdata = '0, auto_rdata = '0;
  assign m_ready = mem_auto ? auto_ready : man_ready;
  assign m_rdata = mem_auto ? auto_rdata : man_rdata;

  iob_vexriscv_dbus_bridge #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_address(cmd_address), .cmd_data(cmd_data), .cmd_mask(cmd_mask), .cmd_size(cmd_size),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready), .err_count(err_count)
  );

  typedef struct { logic [31:0] addr, wdata, rdata; logic [3:0] wstrb; } mreq_t;
  typedef struct { logic [31:0] data; logic err; } rsp_t;
  typedef struct { bit wr; logic [31:0] addr, data; logic [3:0] mask; logic [1:0] size; } cmd_t;

  mreq_t obs_m[$];
  rsp_t  obs_r[$];
  int total = 0, bad = 0, stab_viol = 0, exp_err = 0;

  // Records completed memory transactions and responses; counts any change of
  // a pending request before it completes.
  logic        pend = 1'b0;
  logic [31:0] pa = '0, pd = '0;
  logic [3:0]  ps = '0;
  always @(negedge clk) begin
    if (!rst) pend = 1'b0;
    else begin
      if (pend && (!m_valid || m_address !== pa || m_wdata !== pd || m_wstrb !== ps)) stab_viol++;
      if (m_valid && m_ready) obs_m.push_back('{m_address, m_wdata, m_rdata, m_wstrb});
      if (rsp_valid) obs_r.push_back('{rsp_data, rsp_error});
      pend = m_valid && !m_ready;
      pa = m_address; pd = m_wdata; ps = m_wstrb;
    end
  end

  // Automatic memory: completes each request after 0..3 wait cycles.
  int wait_cnt = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      auto_ready = 1'b0;
      if (mem_auto && m_valid) begin
        if (wait_cnt == 0) begin
          auto_ready = 1'b1;
          auto_rdata = $urandom;
          wait_cnt = $urandom_range(0, 3);
        end else wait_cnt--;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit is_mis(input logic [1:0] size, input logic [31:0] addr);
    case (size)
      2'd0: return 1'b0;
      2'd1: return addr[0];
      2'd2: return addr[1:0] != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input logic [1:0] s);
    int t = 0;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_address = a; cmd_data = d; cmd_mask = m; cmd_size = s;
    while (!cmd_ready && t < 200) begin tick(); t++; end
    total++;
    if (t >= 200) begin bad++; $display("FAIL send_timeout addr=%h cmd_ready stuck at 0, required 1", a); end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got [9];
    logic [31:0] exp [9];
    string nm [9];
    rst = 1'b0;
    repeat (3) tick();
    got = '{32'(cmd_ready), 32'(rsp_valid), rsp_data, 32'(rsp_error), 32'(m_valid),
            m_address, m_wdata, 32'(m_wstrb), 32'(err_count)};
    exp = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    nm  = '{"cmd_ready", "rsp_valid", "rsp_data", "rsp_error", "m_valid",
            "m_address", "m_wdata", "m_wstrb", "err_count"};
    for (int i = 0; i < 9; i++) begin
      total++;
      if (got[i] !== exp[i]) begin bad++; $display("FAIL reset_%s got %h required %h", nm[i], got[i], exp[i]); end
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    int r0 = obs_r.size();
    mem_auto = 1'b0; man_ready = 1'b0;
    tick();
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_address = 32'h100; cmd_size = 2'd2;
    cmd_mask = 4'hF; cmd_data = $urandom;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL sr_accept cmd_ready=%b required 1", cmd_ready); end
    tick(); cmd_valid = 1'b0;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL sr_mvalid_n1 m_valid=%b required 0", m_valid); end
    tick();
    total++;
    if (m_valid !== 1'b1 || m_address !== 32'h100 || m_wstrb !== 4'h0) begin
      bad++; $display("FAIL sr_issue m_valid=%b addr=%h wstrb=%h required 1/00000100/0", m_valid, m_address, m_wstrb);
    end
    repeat (3) tick();
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL sr_hold m_valid=%b required 1", m_valid); end
    man_ready = 1'b1; man_rdata = 32'hDEADBEEF;
    tick(); man_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF || rsp_error !== 1'b0) begin
      bad++; $display("FAIL sr_rsp valid=%b data=%h err=%b required 1/deadbeef/0", rsp_valid, rsp_data, rsp_error);
    end
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL sr_rsp_pulse rsp_valid=%b required 0", rsp_valid); end
    total++; if (obs_r.size() - r0 != 1) begin bad++; $display("FAIL sr_rsp_count got %0d required 1", obs_r.size() - r0); end
  endtask

  task automatic test_write_read();
    int m0 = obs_m.size(), r0 = obs_r.size();
    mem_auto = 1'b1;
    send(1'b1, 32'h200, 32'h12345678, 4'hF, 2'd2);
    send(1'b0, 32'h200, $urandom, 4'hF, 2'd2);
    repeat (25) tick();
    mem_auto = 1'b0;
    total++;
    if (obs_m.size() - m0 != 2) begin bad++; $display("FAIL wr_mcount got %0d required 2", obs_m.size() - m0); end
    else begin
      total++;
      if (obs_m[m0].addr !== 32'h200 || obs_m[m0].wdata !== 32'h12345678 || obs_m[m0].wstrb !== 4'hF) begin
        bad++; $display("FAIL wr_write addr=%h wdata=%h wstrb=%h required 200/12345678/f",
                        obs_m[m0].addr, obs_m[m0].wdata, obs_m[m0].wstrb);
      end
      total++;
      if (obs_m[m0+1].addr !== 32'h200 || obs_m[m0+1].wstrb !== 4'h0) begin
        bad++; $display("FAIL wr_read addr=%h wstrb=%h required 200/0", obs_m[m0+1].addr, obs_m[m0+1].wstrb);
      end
      total++;
      if (obs_r.size() - r0 != 1) begin bad++; $display("FAIL wr_rcount got %0d required 1", obs_r.size() - r0); end
      else begin
        total++;
        if (obs_r[r0].data !== obs_m[m0+1].rdata || obs_r[r0].err !== 1'b0) begin
          bad++; $display("FAIL wr_rdata got %h/%b required %h/0", obs_r[r0].data, obs_r[r0].err, obs_m[m0+1].rdata);
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    int m0 = obs_m.size();
    mem_auto = 1'b0; man_ready = 1'b0;
    tick();
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_address = 32'h300; cmd_data = $urandom; cmd_mask = 4'hF; cmd_size = 2'd2;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL ff_push1 cmd_ready=%b required 1", cmd_ready); end
    tick(); cmd_address = 32'h304;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL ff_push2 cmd_ready=%b required 1", cmd_ready); end
    tick(); cmd_address = 32'h308;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL ff_full cmd_ready=%b required 0", cmd_ready); end
    repeat (2) tick();
    total++;
    if (cmd_ready !== 1'b0 || m_valid !== 1'b1) begin
      bad++; $display("FAIL ff_hold cmd_ready=%b m_valid=%b required 0/1", cmd_ready, m_valid);
    end
    man_ready = 1'b1;
    tick(); man_ready = 1'b0;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL ff_accept3 cmd_ready=%b required 1", cmd_ready); end
    tick(); cmd_valid = 1'b0;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL ff_refull cmd_ready=%b required 0", cmd_ready); end
    mem_auto = 1'b1;
    repeat (25) tick();
    mem_auto = 1'b0;
    total++;
    if (obs_m.size() - m0 != 3) begin bad++; $display("FAIL ff_count got %0d required 3", obs_m.size() - m0); end
    else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs_m[m0+i].addr !== 32'h300 + 32'(4*i)) begin
          bad++; $display("FAIL ff_order%0d addr=%h required %h", i, obs_m[m0+i].addr, 32'h300 + 32'(4*i));
        end
      end
    end
  endtask

  task automatic test_misaligned();
    int m0 = obs_m.size(), r0 = obs_r.size();
    mem_auto = 1'b1;
    send(1'b0, 32'h102, $urandom, 4'hF, 2'd2);
    repeat (8) tick();
    if (exp_err < 255) exp_err++;
    total++; if (obs_m.size() != m0) begin bad++; $display("FAIL mis_rd_nomem got %0d required 0", obs_m.size() - m0); end
    total++;
    if (obs_r.size() - r0 != 1) begin bad++; $display("FAIL mis_rd_rcount got %0d required 1", obs_r.size() - r0); end
    else begin
      total++;
      if (obs_r[r0].data !== 32'h0 || obs_r[r0].err !== 1'b1) begin
        bad++; $display("FAIL mis_rd_rsp got %h/%b required 0/1", obs_r[r0].data, obs_r[r0].err);
      end
    end
    total++; if (err_count !== 8'(exp_err)) begin bad++; $display("FAIL mis_cnt1 got %0d required %0d", err_count, exp_err); end
    send(1'b1, 32'h101, $urandom, 4'h3, 2'd1);
    repeat (8) tick();
    if (exp_err < 255) exp_err++;
    total++;
    if (obs_r.size() - r0 != 1 || obs_m.size() != m0) begin
      bad++; $display("FAIL mis_wr_silent rsp=%0d mem=%0d required 1/0", obs_r.size() - r0, obs_m.size() - m0);
    end
    total++; if (err_count !== 8'(exp_err)) begin bad++; $display("FAIL mis_cnt2 got %0d required %0d", err_count, exp_err); end
    mem_auto = 1'b0;
  endtask

  task automatic test_random();
    cmd_t q[$];
    cmd_t c;
    int m0 = obs_m.size(), r0 = obs_r.size(), sv0 = stab_viol;
    int mi, ri;
    mem_auto = 1'b1;
    for (int i = 0; i < 80; i++) begin
      c.wr = 1'($urandom_range(0, 1));
      c.size = 2'($urandom_range(0, 3));
      c.addr = $urandom;
      if ($urandom_range(0, 1) == 1) c.addr[1:0] = 2'b00;
      c.data = $urandom;
      c.mask = 4'($urandom);
      q.push_back(c);
      repeat ($urandom_range(0, 2)) tick();
      send(c.wr, c.addr, c.data, c.mask, c.size);
    end
    repeat (40) tick();
    mem_auto = 1'b0;
    mi = m0; ri = r0;
    foreach (q[i]) begin
      if (is_mis(q[i].size, q[i].addr)) begin
        if (exp_err < 255) exp_err++;
        if (!q[i].wr) begin
          total++;
          if (ri >= obs_r.size()) begin bad++; $display("FAIL rnd_err_rsp%0d missing response", i); end
          else begin
            if (obs_r[ri].data !== 32'h0 || obs_r[ri].err !== 1'b1) begin
              bad++; $display("FAIL rnd_err_rsp%0d got %h/%b required 0/1", i, obs_r[ri].data, obs_r[ri].err);
            end
            ri++;
          end
        end
      end else begin
        total++;
        if (mi >= obs_m.size()) begin bad++; $display("FAIL rnd_req%0d missing memory request", i); end
        else begin
          if (obs_m[mi].addr !== q[i].addr || obs_m[mi].wstrb !== (q[i].wr ? q[i].mask : 4'h0) ||
              (q[i].wr && obs_m[mi].wdata !== q[i].data)) begin
            bad++; $display("FAIL rnd_req%0d got %h/%h/%h required %h/%h/%h", i, obs_m[mi].addr, obs_m[mi].wdata,
                            obs_m[mi].wstrb, q[i].addr, q[i].data, q[i].wr ? q[i].mask : 4'h0);
          end
          if (!q[i].wr) begin
            total++;
            if (ri >= obs_r.size()) begin bad++; $display("FAIL rnd_rsp%0d missing response", i); end
            else begin
              if (obs_r[ri].data !== obs_m[mi].rdata || obs_r[ri].err !== 1'b0) begin
                bad++; $display("FAIL rnd_rsp%0d got %h/%b required %h/0", i, obs_r[ri].data, obs_r[ri].err, obs_m[mi].rdata);
              end
              ri++;
            end
          end
          mi++;
        end
      end
    end
    total++;
    if (mi != obs_m.size() || ri != obs_r.size()) begin
      bad++; $display("FAIL rnd_extra mem=%0d rsp=%0d required %0d/%0d", obs_m.size(), obs_r.size(), mi, ri);
    end
    total++; if (err_count !== 8'(exp_err)) begin bad++; $display("FAIL rnd_errcnt got %0d required %0d", err_count, exp_err); end
    total++; if (stab_viol != sv0) begin bad++; $display("FAIL rnd_stable violations=%0d required 0", stab_viol - sv0); end
  endtask

  task automatic test_saturation();
    int m0 = obs_m.size(), r0 = obs_r.size();
    mem_auto = 1'b1;
    for (int i = 0; i < 260; i++) begin
      send(1'b1, $urandom, $urandom, 4'hF, 2'd3);
      if (exp_err < 255) exp_err++;
    end
    repeat (10) tick();
    mem_auto = 1'b0;
    total++; if (err_count !== 8'(exp_err)) begin bad++; $display("FAIL sat_errcnt got %0d required %0d", err_count, exp_err); end
    total++; if (err_count !== 8'd255) begin bad++; $display("FAIL sat_max got %0d required 255", err_count); end
    total++;
    if (obs_m.size() != m0 || obs_r.size() != r0) begin
      bad++; $display("FAIL sat_silent mem=%0d rsp=%0d required 0/0", obs_m.size() - m0, obs_r.size() - r0);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got [9];
    logic [31:0] exp [9];
    string nm [9];
    int t = 0;
    int m0 = obs_m.size(), r0 = obs_r.size();
    mem_auto = 1'b0; man_ready = 1'b0;
    tick();
    send(1'b0, 32'h400, $urandom, 4'hF, 2'd2);
    send(1'b1, 32'h404, $urandom, 4'hF, 2'd2);
    while (!m_valid && t < 10) begin tick(); t++; end
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL rm_issue m_valid=%b required 1", m_valid); end
    #1 rst = 1'b0;
    #1;
    got = '{32'(cmd_ready), 32'(rsp_valid), rsp_data, 32'(rsp_error), 32'(m_valid),
            m_address, m_wdata, 32'(m_wstrb), 32'(err_count)};
    exp = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    nm  = '{"cmd_ready", "rsp_valid", "rsp_data", "rsp_error", "m_valid",
            "m_address", "m_wdata", "m_wstrb", "err_count"};
    for (int i = 0; i < 9; i++) begin
      total++;
      if (got[i] !== exp[i]) begin bad++; $display("FAIL rm_%s got %h required %h", nm[i], got[i], exp[i]); end
    end
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();
    man_ready = 1'b1; man_rdata = $urandom;
    tick(); man_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || m_valid !== 1'b0) begin
      bad++; $display("FAIL rm_late_ready rsp_valid=%b m_valid=%b required 0/0", rsp_valid, m_valid);
    end
    repeat (5) tick();
    total++;
    if (obs_r.size() != r0 || obs_m.size() != m0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL rm_empty rsp=%0d mem=%0d cmd_ready=%b required 0/0/1",
                      obs_r.size() - r0, obs_m.size() - m0, cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_fifo_full();
    test_misaligned();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
